// File: rtl/encoder4_to_2_seq.sv
// encoder4_to_2_seq -- registered 4-to-2 request encoder with handshake.
//
// Requests on d0..d3 are latched into a pending register and granted one at a
// time on the a1/a0 output under a valid/ready handshake. A request that
// arrives while its pending bit is already set (and not being granted on that
// edge) is dropped, and ovf pulses for one cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   d0..d3       request lines, sampled on every rising edge
//   ready        consumer accepts a1/a0 when valid & ready
//   a1, a0       encoded index of the granted request (a1 = MSB)
//   valid        a1/a0 hold a granted index
//   ovf          one-cycle pulse: a duplicate request was dropped
//
// Configuration:
//   ENCODER_ROUND_ROBIN_EN  when defined, grants rotate through a 2-bit
//                           pointer; otherwise index 0 has fixed top priority.
module encoder4_to_2_seq (
  input  logic clk,
  input  logic reset,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic ready,
  output logic a1,
  output logic a0,
  output logic valid,
  output logic ovf
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] idx_q, idx_d;
  logic       ovf_q, ovf_d;

  logic [3:0] req;
  logic [3:0] clr_mask;
  logic [1:0] pick;
  logic       any_pend;
  logic       load;
  logic       grant;

  assign req = {d3, d2, d1, d0};

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [1:0] rr_q;
  logic [1:0] probe;

  // Search starts at the pointer and wraps; first pending bit found wins.
  always_comb begin
    pick  = rr_q;
    probe = rr_q;
    for (int j = 3; j >= 0; j--) begin
      probe = rr_q + 2'(j);
      if (pend_q[probe]) pick = probe;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rr_q <= 2'd0;
    else if (grant) rr_q <= pick + 2'd1;
  end
`else
  // Fixed priority: index 0 highest.
  always_comb begin
    pick = 2'd0;
    if      (pend_q[0]) pick = 2'd0;
    else if (pend_q[1]) pick = 2'd1;
    else if (pend_q[2]) pick = 2'd2;
    else if (pend_q[3]) pick = 2'd3;
  end
`endif

  // Next-state / datapath. Selection looks only at registered pending bits,
  // so a request sampled on one edge can be granted on the next at earliest.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    any_pend = |pend_q;
    load     = (state_q == EMPTY) || ready;
    grant    = load && any_pend;
    clr_mask = grant ? (4'b0001 << pick) : 4'b0000;
    // OR-ing the new requests after the clear makes a same-edge set win.
    pend_d   = (pend_q & ~clr_mask) | req;
    // Duplicate: already pending and not being freed on this edge.
    ovf_d    = |(req & pend_q & ~clr_mask);
    if (load) begin
      if (any_pend) begin
        state_d = FULL;
        idx_d   = pick;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      pend_q  <= 4'b0000;
      idx_q   <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid = (state_q == FULL);
  assign a1    = idx_q[1];
  assign a0    = idx_q[0];
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_encoder4_to_2_seq.sv
// Directed self-checking bench for encoder4_to_2_seq.
module tb_encoder4_to_2_seq;

  logic clk = 1'b0;
  logic reset, d0, d1, d2, d3, ready;
  logic a1, a0, valid, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  encoder4_to_2_seq dut (
    .clk(clk), .reset(reset),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ready(ready),
    .a1(a1), .a0(a0), .valid(valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change here, far from next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(4'b0000);
    ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // {valid, a1, a0} packed into one value for compact checks.
  function automatic logic [3:0] out3();
    return {1'b0, valid, a1, a0};
  endfunction

  initial begin
    reset = 1'b1; ready = 1'b1; set_d(4'b0000);
    #2;
    chk("reset_async_outs", {valid, a1, a0, ovf}, 4'b0000);
    do_reset();
    chk("reset_state", {valid, a1, a0, ovf}, 4'b0000);

    // Single request on d2.
    set_d(4'b0100); step(); set_d(4'b0000);
    chk("single_no_early", out3(), 4'b0000);
    step();
    chk("single_grant", out3(), 4'b0110);
    step();
    chk("single_drop", {3'b000, valid}, 4'b0000);

    // Fixed-priority burst: all four in one cycle.
    do_reset();
    set_d(4'b1111); step(); set_d(4'b0000);
    step(); chk("burst_g0", out3(), 4'b0100);
    step(); chk("burst_g1", out3(), 4'b0101);
    step(); chk("burst_g2", out3(), 4'b0110);
    step(); chk("burst_g3", out3(), 4'b0111);
    step(); chk("burst_end", {3'b000, valid}, 4'b0000);

    // Backpressure: grant of index 1 held for five cycles.
    do_reset();
    ready = 1'b0;
    set_d(4'b0010); step(); set_d(4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), out3(), 4'b0101);
    end
    ready = 1'b1;
    step();
    chk("bp_release", {3'b000, valid}, 4'b0000);

    // Duplicate on d3 while a grant is stalled.
    do_reset();
    ready = 1'b0;
    set_d(4'b0001); step(); set_d(4'b0000);
    step(); chk("dup_hold0", out3(), 4'b0100);
    set_d(4'b1000); step();
    chk("dup_first_no_ovf", {3'b000, ovf}, 4'b0000);
    step();
    chk("dup_ovf", {3'b000, ovf}, 4'b0001);
    set_d(4'b0000); step();
    chk("dup_ovf_pulse_end", {3'b000, ovf}, 4'b0000);
    ready = 1'b1;
    step(); chk("dup_grant3", out3(), 4'b0111);
    step(); chk("dup_single", {3'b000, valid}, 4'b0000);
    step(); chk("dup_none_more", {3'b000, valid}, 4'b0000);

    // d0/d1 re-asserted every cycle with ready held high.
    do_reset();
    set_d(4'b0011); step();
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef ENCODER_ROUND_ROBIN_EN
      chk($sformatf("rr_g%0d", i), out3(), (i % 2 == 0) ? 4'b0100 : 4'b0101);
`else
      chk($sformatf("fixed_g%0d", i), out3(), 4'b0100);
`endif
    end
    set_d(4'b0000);

    // Asynchronous reset mid-operation with everything pending.
    do_reset();
    ready = 1'b0;
    set_d(4'b1111); step(); step();
    chk("mid_pre_valid", out3(), 4'b0100);
    chk("mid_pre_ovf", {3'b000, ovf}, 4'b0001);
    set_d(4'b0000);
    #2 reset = 1'b1;
    #1;
    chk("mid_async_clear", {valid, a1, a0, ovf}, 4'b0000);
    step();
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mid_after%0d", i), {valid, a1, a0, ovf}, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder4_to_2_seq.md
ENCODER4_TO_2_SEQ -- requirements
Module: encoder4_to_2_seq

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 d0, d1, d2, d3  input  1 each  request lines; a 1 sampled on a clk edge raises one request for that index.
REQ-005 a0, a1  output  1 each  encoded index of the granted request (a1 = MSB, a0 = LSB).
REQ-006 valid  output  1  a1/a0 hold a granted index.
REQ-007 ready  input  1  consumer accepts a1/a0 on any edge where valid=1 and ready=1.
REQ-008 ovf  output  1  one-cycle pulse: a request was dropped as a duplicate.

Function
REQ-009 Internal 4-bit pending register P; bit i set on any edge where di=1.
REQ-010 Output FSM has two states: EMPTY (valid=0) and FULL (valid=1).
REQ-011 Load condition L = (state EMPTY) or (state FULL and ready=1).
REQ-012 On an edge with L=1 and P nonzero: select index k from P by the priority rule, drive {a1,a0}=k, valid=1, state FULL, clear P[k].
REQ-013 On an edge with L=1 and P zero: valid=0, state EMPTY; a1/a0 retain last value.
REQ-014 In FULL with ready=0: a1, a0, valid held stable; P not cleared.
REQ-015 Selection uses registered P only, never raw d inputs; di sampled at edge N yields valid at edge N+1 at the earliest.
REQ-016 Same-edge set and clear of P[k] (dk=1 while k granted): set wins, P[k] stays 1.
REQ-017 ovf=1 for one cycle when di=1 while P[i]=1 and P[i] is not cleared on that edge; the duplicate request is lost; ovf=0 otherwise.
REQ-018 Multiple d lines asserted on one edge all set their P bits; granted one per accepted transfer, back-to-back when ready=1 (one grant per cycle).
REQ-019 Default priority is fixed: index 0 highest, index 3 lowest.
REQ-020 Throughput: with ready=1 held and P nonzero, one grant per clock, no bubble cycles.

Reset
REQ-021 reset=1 forces asynchronously: P=0000, state EMPTY, valid=0, a1=0, a0=0, ovf=0, round-robin pointer=0.
REQ-022 Reset mid-transfer discards the held grant and all pending requests; no output for them after release.
REQ-023 First grant possible on the second rising edge after reset deasserts with a request present on the first.

Configuration
REQ-024 Macro ENCODER_ROUND_ROBIN_EN selects the priority rule.
REQ-025 Without ENCODER_ROUND_ROBIN_EN: fixed priority per REQ-019; no pointer register exists.
REQ-026 With ENCODER_ROUND_ROBIN_EN: 2-bit pointer R (reset 0); search order R, R+1, R+2, R+3 mod 4; after granting k, R becomes (k+1) mod 4; R unchanged when nothing granted.

Verification
REQ-027 Single request: reset, d2=1 for one cycle, ready=1 -> next edge valid=1, {a1,a0}=10, following edge valid=0.
REQ-028 Fixed priority burst: d0..d3 all 1 for one cycle, ready=1 -> grants 00,01,10,11 on four consecutive cycles, then valid=0.
REQ-029 Backpressure: d1 pulse, ready=0 for 5 cycles -> valid=1, {a1,a0}=01 stable all 5 cycles; ready=1 -> valid drops next edge.
REQ-030 Duplicate: d3=1 two consecutive cycles while d0 pending and ready=0 -> ovf=1 exactly one cycle; only one grant of 11 after release.
REQ-031 Round robin (macro defined): d0 and d1 re-asserted every cycle, ready=1 -> grants alternate 00,01,00,01; without macro -> 00 repeatedly.
REQ-032 Reset mid-operation: P=1111, valid=1, assert reset between edges -> valid, a1, a0, ovf go 0 immediately; no grants after release without new requests.
